// File: rtl/idht16_seq_if.sv
// ============================================================================
// Module   : idht16_seq_if
// Brief    : Coefficient-in / sample-out handshake bundle for idht16_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface idht16_seq_if #(
  parameter int IW = 12,
  parameter int OW = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic [3:0]           out_idx;
  logic                 out_last;
  logic                 sat;
  logic                 inexact;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, sat, inexact
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, sat, inexact
  );
endinterface

`default_nettype wire

// File: rtl/idht16_seq.sv
// ============================================================================
// Module   : idht16_seq
// Brief    : Sequential 16-point inverse Walsh-Hadamard transform (natural order).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idht16_seq #(
  parameter int IW = 12,
  parameter int OW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  idht16_seq_if.slave bus
);

  localparam int BW = IW + 4;

  localparam logic [1:0] c_LOAD  = 2'd0;
  localparam logic [1:0] c_XFORM = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic signed [BW-1:0] c_SMAX = BW'((2 ** (OW - 1)) - 1);
  localparam logic signed [BW-1:0] c_SMIN = BW'(-(2 ** (OW - 1)));

  logic [1:0]           r_state;
  logic [3:0]           r_wr_cnt;
  logic [3:0]           r_rd_cnt;
  logic [1:0]           r_stage;
  logic                 r_in_ready;
  logic                 r_sat;
  logic                 r_inexact;
  logic signed [BW-1:0] r_buf [16];

  logic signed [BW-1:0] w_bf [16];
  logic [3:0]           w_stride;
  logic signed [BW-1:0] w_cur;
  logic signed [BW-1:0] w_shift;
  logic signed [BW-1:0] w_sel;
  logic                 w_drain;
  logic                 w_clip;
  logic                 w_frac;
  logic                 w_in_fire;
  logic                 w_out_fire;

  assign w_drain    = (r_state == c_DRAIN);
  assign w_cur      = r_buf[r_rd_cnt];
  assign w_shift    = w_cur >>> 4;
  assign w_clip     = w_drain && ((w_shift > c_SMAX) || (w_shift < c_SMIN));
  assign w_frac     = w_drain && (w_cur[3:0] != 4'd0);
  assign w_in_fire  = (r_state == c_LOAD) && r_in_ready && bus.in_valid;
  assign w_out_fire = w_drain && bus.out_ready;

  // One radix-2 stage: stride 8,4,2,1 for stage 0..3; upper element of each pair takes the difference.
  always_comb begin
    w_stride = 4'd8 >> r_stage;
    for (int j = 0; j < 16; j++) begin
      if ((4'(j) & w_stride) == 4'd0)
        w_bf[j] = r_buf[j] + r_buf[4'(j) | w_stride];
      else
        w_bf[j] = r_buf[4'(j) & ~w_stride] - r_buf[j];
    end
  end

  always_comb begin
    w_sel = w_shift;
    if (w_shift > c_SMAX)
      w_sel = c_SMAX;
    else if (w_shift < c_SMIN)
      w_sel = c_SMIN;
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_drain;
  assign bus.out_data  = w_drain ? w_sel[OW-1:0] : '0;
  assign bus.out_idx   = r_rd_cnt;
  assign bus.out_last  = w_drain && (r_rd_cnt == 4'hF);
  assign bus.sat       = r_sat | w_clip;
  assign bus.inexact   = r_inexact | w_frac;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_LOAD;
      r_wr_cnt   <= 4'd0;
      r_rd_cnt   <= 4'd0;
      r_stage    <= 2'd0;
      r_in_ready <= 1'b0;
      r_sat      <= 1'b0;
      r_inexact  <= 1'b0;
    end else if (flush) begin
      r_state    <= c_LOAD;
      r_wr_cnt   <= 4'd0;
      r_rd_cnt   <= 4'd0;
      r_stage    <= 2'd0;
      r_in_ready <= 1'b1;
      r_sat      <= 1'b0;
      r_inexact  <= 1'b0;
    end else begin
      case (r_state)
        c_LOAD: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_wr_cnt <= r_wr_cnt + 4'd1;
            if (r_wr_cnt == 4'hF) begin
              r_state    <= c_XFORM;
              r_stage    <= 2'd0;
              r_in_ready <= 1'b0;
            end
          end
        end
        c_XFORM: begin
          r_stage <= r_stage + 2'd1;
          if (r_stage == 2'd3)
            r_state <= c_DRAIN;
        end
        c_DRAIN: begin
          if (w_clip) r_sat     <= 1'b1;
          if (w_frac) r_inexact <= 1'b1;
          if (w_out_fire) begin
            r_rd_cnt <= r_rd_cnt + 4'd1;
            if (r_rd_cnt == 4'hF) begin
              r_state    <= c_LOAD;
              r_rd_cnt   <= 4'd0;
              r_wr_cnt   <= 4'd0;
              r_sat      <= 1'b0;
              r_inexact  <= 1'b0;
              r_in_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= c_LOAD;
          r_wr_cnt   <= 4'd0;
          r_rd_cnt   <= 4'd0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Data buffer carries no reset; its contents are only consumed after a full load.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (w_in_fire)
        r_buf[r_wr_cnt] <= {{4{bus.in_data[IW-1]}}, bus.in_data};
      else if (r_state == c_XFORM)
        for (int j = 0; j < 16; j++)
          r_buf[j] <= w_bf[j];
    end
  end

endmodule

`default_nettype wire

// File: doc/idht16_seq.md
IDHT16_SEQ -- requirements
Module: idht16_seq

Interface
REQ-001 SHALL have parameter IW, default 12: signed input coefficient width, equal to the forward 16-point transform output width.
REQ-002 SHALL have parameter OW, default 8: signed reconstructed sample width.
REQ-003 SHALL have port clk  input  1: the single clock; all logic is posedge clk.
REQ-004 SHALL have port rst_n  input  1: asynchronous reset, active low.
REQ-005 SHALL have port flush  input  1: synchronous abort of the current block.
REQ-006 SHALL have port in_valid  input  1: in_data is valid.
REQ-007 SHALL have port in_ready  output  1: block accepts in_data.
REQ-008 SHALL have port in_data  input  IW: signed coefficient Y[k], presented in order k=0..15.
REQ-009 SHALL have port out_valid  output  1: out_data is valid.
REQ-010 SHALL have port out_ready  input  1: downstream accepts out_data.
REQ-011 SHALL have port out_data  output  OW: signed reconstructed sample x[n].
REQ-012 SHALL have port out_idx  output  4: index n of out_data.
REQ-013 SHALL have port out_last  output  1: high with n=15.
REQ-014 SHALL have port sat  output  1: sticky per block; at least one output was clipped.
REQ-015 SHALL have port inexact  output  1: sticky per block; at least one accumulated value was not a multiple of 16.

Function
REQ-016 SHALL compute x[n] = (1/16)·sum_k H16[n][k]·Y[k], where H16 is the natural-ordered (Sylvester) Hadamard matrix; this is the exact inverse of the team's 16-point forward transform.
REQ-017 SHALL use three FSM states: LOAD, XFORM and DRAIN.
REQ-018 SHALL use a 16-entry register buffer of width IW+4, in which all internal arithmetic is done.
REQ-019 In LOAD: in_ready=1; each in_valid&in_ready beat SHALL write buffer[wr_cnt], sign-extended, and increment wr_cnt.
REQ-020 When the beat with wr_cnt=15 is accepted, the FSM SHALL go to XFORM on the next edge.
REQ-021 In XFORM: in_ready=0, and exactly 4 cycles SHALL run, one butterfly stage per cycle, with stride 8, 4, 2, 1 in that order.
REQ-022 Each stage SHALL update all 8 pairs (i, i+stride) in place: b[i]<=b[i]+b[i+stride] and b[i+stride]<=b[i]-b[i+stride], for i with bit log2(stride) equal to 0.
REQ-023 The FSM SHALL enter DRAIN after the 4th stage; out_valid SHALL rise on the first cycle in DRAIN, 5 cycles after the 16th input beat was accepted.
REQ-024 In DRAIN, out_data SHALL be b[rd_cnt] arithmetically shifted right by 4, then saturated to the range [-2^(OW-1), 2^(OW-1)-1].
REQ-025 In DRAIN, out_idx SHALL equal rd_cnt.
REQ-026 rd_cnt SHALL advance only on out_valid&out_ready; out_data, out_idx and out_valid SHALL hold stable while out_ready=0.
REQ-027 The beat with rd_cnt=15 accepted SHALL return the FSM to LOAD with wr_cnt=rd_cnt=0; in_ready SHALL be 1 on the following cycle.
REQ-028 sat SHALL set when a DRAIN value is clipped; inexact SHALL set when any b[n][3:0]!=0 is presented.
REQ-029 sat and inexact SHALL clear on entry to LOAD from DRAIN.
REQ-030 No input SHALL be accepted outside LOAD; input and output phases SHALL NOT overlap.
REQ-031 flush=1 SHALL go to LOAD with wr_cnt=rd_cnt=0 and clear sat and inexact; it SHALL win over a simultaneous in or out handshake; buffer contents are don't-care.
REQ-032 Wrap-around: wr_cnt and rd_cnt are 4-bit and SHALL never pass 15 inside a block.

Reset
REQ-033 rst_n=0 SHALL force immediately state=LOAD, wr_cnt=0, rd_cnt=0, in_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0, sat=0, inexact=0.
REQ-034 After release, in_ready SHALL be 1 from the first clk edge.
REQ-035 Reset asserted mid-LOAD, mid-XFORM or mid-DRAIN SHALL discard the block; no partial output SHALL appear after release.
REQ-036 Buffer registers need no reset value.

Verification
REQ-037 Impulse: Y = 16 beats of +5 -> x = [5,0,...,0], out_idx 0..15, out_last on idx 15, sat=0, inexact=0, first out_valid 5 cycles after the last input beat.
REQ-038 DC: Y = [16,0,...,0] -> all 16 outputs = 1; Y = [-16,0,...,0] -> all 16 outputs = -1.
REQ-039 Inexact: Y = [1,0,...,0] -> all outputs 0 (1>>>4), inexact=1, sat=0; next block clean -> inexact back to 0.
REQ-040 Saturation: Y = [2047,0,...,0]×... all 2047 -> x[0] = 2047 clipped to 127 with sat=1; x[1..15] = 0.
REQ-041 Backpressure: out_ready toggled at random, plus a 10-cycle stall at idx 7 -> no sample dropped or duplicated, outputs held stable during the stall, in_ready=0 throughout DRAIN.
REQ-042 Abort: rst_n pulsed low in XFORM stage 2, and separately flush at wr_cnt=9 -> LOAD, in_ready=1, no out_valid; the next full block is reconstructed correctly.
